// File: rtl/line_buf_sched.sv
// line_buf_sched: control for a ring of NUM_BUFS line buffers.
// Each incoming line is steered into the next free buffer. Lines are popped to
// the window stage in the order they were written. When no buffer is free, the
// whole line is dropped and a sticky overflow flag is set. Pixel data does not
// pass through this block; it only drives write gates, pop strobes and selects.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   in_beat_i         input beat valid
//   in_line_start_i   first beat of a line (qualified by in_beat_i)
//   in_line_end_i     last beat of a line (qualified by in_beat_i)
//   out_ready_i       downstream can take a whole line (sampled only in IDLE)
//   buf_line_end_i    read-side line_end of each buffer
//   wr_en_o           one-hot push gate (combinational)
//   wr_sel_o          index of the buffer being written
//   pop_line_o        one-cycle pop strobe per buffer
//   rd_sel_o          read mux select
//   rd_active_o       a line read is in progress
//   occupancy_o       committed unread lines, 0..NUM_BUFS
//   overflow_o        sticky: at least one line was dropped
//   clr_overflow_i    clears overflow_o (a simultaneous new drop wins)
module line_buf_sched #(
  parameter  int NUM_BUFS = 4,
  localparam int IDX_W    = $clog2(NUM_BUFS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_beat_i,
  input  logic                in_line_start_i,
  input  logic                in_line_end_i,
  input  logic                out_ready_i,
  input  logic [NUM_BUFS-1:0] buf_line_end_i,
  output logic [NUM_BUFS-1:0] wr_en_o,
  output logic [IDX_W-1:0]    wr_sel_o,
  output logic [NUM_BUFS-1:0] pop_line_o,
  output logic [IDX_W-1:0]    rd_sel_o,
  output logic                rd_active_o,
  output logic [IDX_W:0]      occupancy_o,
  output logic                overflow_o,
  input  logic                clr_overflow_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_READ = 2'd2
  } rd_state_e;

  localparam logic [IDX_W:0]   FULL_OCC = (IDX_W+1)'(NUM_BUFS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUFS - 1);

  // Ring increment; NUM_BUFS need not be a power of two.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == LAST_IDX) begin
      next_idx = {IDX_W{1'b0}};
    end else begin
      next_idx = idx + IDX_W'(1'b1);
    end
  endfunction

  rd_state_e        state_r, state_nxt_s;
  logic [IDX_W-1:0] wr_idx_r, rd_idx_r;
  logic [IDX_W:0]   occupancy_r;
  logic             drop_r, in_line_r, overflow_r;

  logic start_beat_s, end_beat_s, start_drop_s;
  logic drop_eff_s, in_line_eff_s, wr_go_s, commit_s, pop_s;

  assign start_beat_s = in_beat_i & in_line_start_i;
  assign end_beat_s   = in_beat_i & in_line_end_i;
  assign pop_s        = (state_r == ST_POP);

  // Committed lines sit contiguously just behind wr_idx. So wr_idx can only hold
  // an unread line when the ring is full. The other busy case is the buffer
  // that is currently being popped or read.
  assign start_drop_s = (occupancy_r == FULL_OCC) ||
                        ((state_r != ST_IDLE) && (wr_idx_r == rd_idx_r));

  // The start beat uses its own fresh decision, which also covers single-beat lines.
  assign drop_eff_s    = start_beat_s ? start_drop_s : drop_r;
  assign in_line_eff_s = start_beat_s | in_line_r;
  assign wr_go_s       = in_beat_i & in_line_eff_s & ~drop_eff_s;
  assign commit_s      = end_beat_s & in_line_eff_s & ~drop_eff_s;

  // One-hot push gate for the buffer being written.
  always_comb begin
    wr_en_o = {NUM_BUFS{1'b0}};
    if (wr_go_s && !rst_i) begin
      wr_en_o[wr_idx_r] = 1'b1;
    end else begin
      wr_en_o = {NUM_BUFS{1'b0}};
    end
  end

  // Write-side state: line tracking, drop decision, ring pointer and sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_idx_r   <= {IDX_W{1'b0}};
      drop_r     <= 1'b0;
      in_line_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (start_beat_s) begin
        drop_r    <= start_drop_s;
        in_line_r <= 1'b1;
      end
      // A line end closes the line; a dropped line's drop flag clears here.
      if (end_beat_s) begin
        drop_r    <= 1'b0;
        in_line_r <= 1'b0;
      end
      if (commit_s) begin
        wr_idx_r <= next_idx(wr_idx_r);
      end
      if (start_beat_s && start_drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow_i) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Occupancy counter: +1 on commit, -1 on pop; both together leave it unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupancy_r <= {(IDX_W+1){1'b0}};
    end else begin
      case ({commit_s, pop_s})
        2'b10:   occupancy_r <= occupancy_r + (IDX_W+1)'(1'b1);
        2'b01:   occupancy_r <= occupancy_r - (IDX_W+1)'(1'b1);
        default: occupancy_r <= occupancy_r;
      endcase
    end
  end

  // Read FSM state register and read pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      rd_idx_r <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_READ) && buf_line_end_i[rd_idx_r]) begin
        rd_idx_r <= next_idx(rd_idx_r);
      end
    end
  end

  // Read FSM next state: the wait in IDLE enforces at least one idle cycle between lines.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((occupancy_r != {(IDX_W+1){1'b0}}) && out_ready_i) begin
          state_nxt_s = ST_POP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_POP:  state_nxt_s = ST_READ;
      ST_READ: begin
        // Only the selected buffer's line_end counts.
        if (buf_line_end_i[rd_idx_r]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pop strobe decoded from the registered state and read pointer.
  always_comb begin
    pop_line_o = {NUM_BUFS{1'b0}};
    if (pop_s) begin
      pop_line_o[rd_idx_r] = 1'b1;
    end else begin
      pop_line_o = {NUM_BUFS{1'b0}};
    end
  end

  assign rd_active_o = (state_r == ST_READ);
  assign wr_sel_o    = wr_idx_r;
  assign rd_sel_o    = rd_idx_r;
  assign occupancy_o = occupancy_r;
  assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_line_buf_sched.sv
// Testbench for line_buf_sched (NUM_BUFS=4): a directed vector table, hand-written
// overflow and reset sequences, and random traffic checked against a reference model.
module tb_line_buf_sched;
  localparam int NB = 4;
  localparam int IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_beat_i, in_line_start_i, in_line_end_i, out_ready_i, clr_overflow_i;
  logic [NB-1:0] buf_line_end_i;
  logic [NB-1:0] wr_en_o, pop_line_o;
  logic [IW-1:0] wr_sel_o, rd_sel_o;
  logic [IW:0]   occupancy_o;
  logic          rd_active_o, overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  line_buf_sched #(.NUM_BUFS(NB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_beat_i(in_beat_i), .in_line_start_i(in_line_start_i), .in_line_end_i(in_line_end_i),
    .out_ready_i(out_ready_i), .buf_line_end_i(buf_line_end_i),
    .wr_en_o(wr_en_o), .wr_sel_o(wr_sel_o), .pop_line_o(pop_line_o), .rd_sel_o(rd_sel_o),
    .rd_active_o(rd_active_o), .occupancy_o(occupancy_o), .overflow_o(overflow_o),
    .clr_overflow_i(clr_overflow_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buffer contents are tracked per buffer ("holds an unread line"). The read
  // side is tracked as a phase: 0 idle, 1 pop, 2 read.
  bit m_holds[NB];
  int m_wr, m_rd, m_phase;
  bit m_drop, m_inl, m_ovf;
  bit m_start_drop, m_drop_eff, m_inl_eff;
  int m_exp_wr;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NB; i++) c += m_holds[i];
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NB; i++) m_holds[i] = 1'b0;
    m_wr = 0; m_rd = 0; m_phase = 0;
    m_drop = 0; m_inl = 0; m_ovf = 0;
  endtask

  task automatic m_comb();
    bit start;
    start = in_beat_i && in_line_start_i;
    m_start_drop = m_holds[m_wr] || (m_phase != 0 && m_rd == m_wr) || (m_count() == NB);
    m_drop_eff = start ? m_start_drop : m_drop;
    m_inl_eff  = start ? 1'b1 : m_inl;
    m_exp_wr   = (in_beat_i && m_inl_eff && !m_drop_eff) ? (1 << m_wr) : 0;
  endtask

  task automatic m_update();
    bit start, endb, commit;
    int cnt, ph;
    start  = in_beat_i && in_line_start_i;
    endb   = in_beat_i && in_line_end_i;
    commit = endb && m_inl_eff && !m_drop_eff;
    cnt = m_count();
    ph  = m_phase;
    if (ph == 0) begin
      if (cnt > 0 && out_ready_i) m_phase = 1;
    end else if (ph == 1) begin
      m_holds[m_rd] = 1'b0;
      m_phase = 2;
    end else begin
      if (buf_line_end_i[m_rd]) begin
        m_rd = (m_rd + 1) % NB;
        m_phase = 0;
      end
    end
    if (start) begin m_drop = m_start_drop; m_inl = 1'b1; end
    if (endb)  begin m_drop = 1'b0; m_inl = 1'b0; end
    if (commit) begin
      m_holds[m_wr] = 1'b1;
      m_wr = (m_wr + 1) % NB;
    end
    if (start && m_start_drop) m_ovf = 1'b1;
    else if (clr_overflow_i) m_ovf = 1'b0;
  endtask

  task automatic chk_regs();
    chk("occupancy", int'(occupancy_o), m_count());
    chk("pop_line", int'(pop_line_o), (m_phase == 1) ? (1 << m_rd) : 0);
    chk("rd_active", int'(rd_active_o), (m_phase == 2) ? 1 : 0);
    chk("rd_sel", int'(rd_sel_o), m_rd);
    chk("wr_sel", int'(wr_sel_o), m_wr);
    chk("overflow", int'(overflow_o), int'(m_ovf));
  endtask

  // Called just after a falling edge with the inputs already applied.
  task automatic run_cycle();
    #1;
    m_comb();
    chk("wr_en", int'(wr_en_o), m_exp_wr);
    @(posedge clk_i);
    m_update();
    @(negedge clk_i);
    chk_regs();
  endtask

  task automatic idle_inputs();
    in_beat_i = 0; in_line_start_i = 0; in_line_end_i = 0;
    out_ready_i = 0; buf_line_end_i = '0; clr_overflow_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    m_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_occupancy", int'(occupancy_o), 0);
    chk("rst_wr_sel", int'(wr_sel_o), 0);
    chk("rst_rd_sel", int'(rd_sel_o), 0);
    chk("rst_pop", int'(pop_line_o), 0);
    chk("rst_active", int'(rd_active_o), 0);
    chk("rst_overflow", int'(overflow_o), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       beat, ls, le, rdy;
    logic [3:0] bend;
    logic       clr;
    logic [3:0] ewr;   // wr_en_o during the row
    int         eocc;  // values after the clock edge
    logic [3:0] epop;
    logic       eact;
    int         erds, ewrs;
    logic       eovf;
  } vec_t;

  vec_t tbl[18];

  int gen_rem;

  initial begin
    tbl[0]  = '{1'b1,1'b1,1'b1,1'b0,4'h0,1'b0, 4'h1, 1,4'h0,1'b0,0,1,1'b0}; // single-beat line
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,4'h0,1'b0, 4'h0, 1,4'h0,1'b0,0,1,1'b0}; // stray beat
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,4'h0,1'b0, 4'h2, 1,4'h0,1'b0,0,1,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,4'h0,1'b0, 4'h2, 2,4'h0,1'b0,0,2,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,4'h0,1'b0, 4'h0, 2,4'h1,1'b0,0,2,1'b0}; // -> POP
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,4'h0,1'b0, 4'h0, 1,4'h0,1'b1,0,2,1'b0}; // -> READ
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,4'h2,1'b0, 4'h0, 1,4'h0,1'b1,0,2,1'b0}; // wrong buffer end
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,4'h1,1'b0, 4'h0, 1,4'h0,1'b0,1,2,1'b0}; // end -> IDLE
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,4'h0,1'b0, 4'h4, 2,4'h0,1'b0,1,3,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,4'h0,1'b0, 4'h8, 3,4'h2,1'b0,1,0,1'b0}; // wr wraps 3->0
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0,4'h0,1'b0, 4'h1, 3,4'h0,1'b1,1,1,1'b0}; // commit + pop
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0,4'h0,1'b0, 4'h0, 3,4'h0,1'b1,1,1,1'b1}; // wr hits reading buf
    tbl[12] = '{1'b1,1'b0,1'b1,1'b0,4'h0,1'b0, 4'h0, 3,4'h0,1'b1,1,1,1'b1};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,4'h0,1'b1, 4'h0, 3,4'h0,1'b1,1,1,1'b0}; // clear
    tbl[14] = '{1'b1,1'b1,1'b0,1'b0,4'h0,1'b1, 4'h0, 3,4'h0,1'b1,1,1,1'b1}; // drop beats clear
    tbl[15] = '{1'b1,1'b0,1'b1,1'b0,4'h2,1'b0, 4'h0, 3,4'h0,1'b0,2,1,1'b1};
    tbl[16] = '{1'b1,1'b1,1'b1,1'b0,4'h0,1'b0, 4'h2, 4,4'h0,1'b0,2,2,1'b1}; // fills ring
    tbl[17] = '{1'b1,1'b1,1'b1,1'b0,4'h0,1'b0, 4'h0, 4,4'h0,1'b0,2,2,1'b1}; // full -> drop

    do_reset();
    for (int i = 0; i < 18; i++) begin
      in_beat_i = tbl[i].beat; in_line_start_i = tbl[i].ls; in_line_end_i = tbl[i].le;
      out_ready_i = tbl[i].rdy; buf_line_end_i = tbl[i].bend; clr_overflow_i = tbl[i].clr;
      #1;
      chk($sformatf("tbl%0d_wr_en", i), int'(wr_en_o), int'(tbl[i].ewr));
      @(negedge clk_i);
      chk($sformatf("tbl%0d_occ", i), int'(occupancy_o), tbl[i].eocc);
      chk($sformatf("tbl%0d_pop", i), int'(pop_line_o), int'(tbl[i].epop));
      chk($sformatf("tbl%0d_act", i), int'(rd_active_o), int'(tbl[i].eact));
      chk($sformatf("tbl%0d_rd_sel", i), int'(rd_sel_o), tbl[i].erds);
      chk($sformatf("tbl%0d_wr_sel", i), int'(wr_sel_o), tbl[i].ewrs);
      chk($sformatf("tbl%0d_ovf", i), int'(overflow_o), int'(tbl[i].eovf));
    end

    // Five 8-beat lines into four buffers with downstream stalled.
    do_reset();
    for (int l = 0; l < 5; l++) begin
      for (int b = 0; b < 8; b++) begin
        in_beat_i = 1; in_line_start_i = (b == 0); in_line_end_i = (b == 7);
        run_cycle();
      end
    end
    idle_inputs();
    chk("ovf5_occupancy", int'(occupancy_o), 4);
    chk("ovf5_overflow", int'(overflow_o), 1);
    chk("ovf5_wr_sel", int'(wr_sel_o), 0);
    clr_overflow_i = 1;
    run_cycle();
    clr_overflow_i = 0;
    chk("ovf5_cleared", int'(overflow_o), 0);

    // Reset asserted in the middle of a read.
    out_ready_i = 1;
    run_cycle();
    run_cycle();
    chk("pre_rst_active", int'(rd_active_o), 1);
    #2 rst_i = 1'b1;
    m_reset();
    #1;
    chk("midrst_occupancy", int'(occupancy_o), 0);
    chk("midrst_active", int'(rd_active_o), 0);
    chk("midrst_pop", int'(pop_line_o), 0);
    chk("midrst_rd_sel", int'(rd_sel_o), 0);
    chk("midrst_wr_sel", int'(wr_sel_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_inputs();
    in_beat_i = 1; in_line_start_i = 1; in_line_end_i = 1;
    #1;
    chk("post_rst_wr_en", int'(wr_en_o), 1);
    #0 run_cycle_after_settle();

    // Random traffic against the model.
    do_reset();
    gen_rem = 0;
    for (int c = 0; c < 3000; c++) begin
      in_beat_i = ($urandom_range(0, 9) < 7);
      in_line_start_i = 0; in_line_end_i = 0;
      if (in_beat_i) begin
        if (gen_rem == 0 && $urandom_range(0, 9) < 8) begin
          in_line_start_i = 1;
          gen_rem = $urandom_range(1, 5);
        end
        if (gen_rem > 0) begin
          gen_rem--;
          in_line_end_i = (gen_rem == 0);
        end
      end
      out_ready_i = $urandom_range(0, 1);
      buf_line_end_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      clr_overflow_i = ($urandom_range(0, 15) == 0);
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Completes the cycle started after reset release (wr_en already sampled).
  task automatic run_cycle_after_settle();
    m_comb();
    chk("post_rst_model_wr_en", int'(wr_en_o), m_exp_wr);
    @(posedge clk_i);
    m_update();
    @(negedge clk_i);
    chk_regs();
    idle_inputs();
  endtask

endmodule
